regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the pipeline CPU, the successor to the fixed 32x32 2-read file.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clear_fsm.sv | 71 +++++++
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_CLEAR,
    RF_DONE
  } rf_state_t;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  function automatic int unsigned rf_depth(input int unsigned addrW);
    return 32'd1 << addrW;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential bulk-clear engine: walks every entry once, one per cycle,
// then emits a single clr_done pulse.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_ptr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_t         state, stateNext;
  logic [ADDR_W-1:0] ptr, ptrNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    busy      = 1'b0;
    clr_done  = 1'b0;
    clr_we    = 1'b0;
    unique case (state)
      RF_IDLE: begin
        if (clr_req) begin
          stateNext = RF_CLEAR;
          ptrNext   = '0;
        end
      end
      RF_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        // Leave at the last index instead of letting the pointer wrap.
        if (ptr == LAST_IDX) begin
          stateNext = RF_DONE;
          ptrNext   = '0;
        end else begin
          ptrNext = ptr + 1'b1;
        end
      end
      RF_DONE: begin
        clr_done = 1'b1;
        if (clr_req) begin
          stateNext = RF_CLEAR;
          ptrNext   = '0;
        end else begin
          stateNext = RF_IDLE;
        end
      end
      default: stateNext = RF_IDLE;
    endcase
  end

  assign clr_ptr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-read-port register file with bulk clear and debug port.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              busyInt;
  logic              clrWe;
  logic [ADDR_W-1:0] clrPtr;
  logic              wrZero;
  logic              wrEn;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) uClear (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busyInt),
    .clr_done (clr_done),
    .clr_we   (clrWe),
    .clr_ptr  (clrPtr)
  );

  assign busy   = busyInt;
  assign wrZero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wrEn   = we && !busyInt && !wrZero;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clrWe) begin
      regs[clrPtr] <= '0;
    end else if (wrEn) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if ((ZERO_REG != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wrEn && (rd_addr[k*ADDR_W +: ADDR_W] == wr_addr)) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
`endif
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, clear sequences and
// randomized traffic against an array-based reference model.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic        we;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        clrReq;
  logic        busy;
  logic        clrDone;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;
  logic [31:0] rdDataB;
  logic        busyB;
  logic        clrDoneB;
  logic [31:0] dbgDataB;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdData), .we(we),
    .wr_addr(wrAddr), .wr_data(wrData), .clr_req(clrReq), .busy(busy),
    .clr_done(clrDone), .dbg_addr(dbgAddr), .dbg_data(dbgData)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst), .rd_addr(rdAddr[4:0]), .rd_data(rdDataB), .we(we),
    .wr_addr(wrAddr), .wr_data(wrData), .clr_req(clrReq), .busy(busyB),
    .clr_done(clrDoneB), .dbg_addr(dbgAddr), .dbg_data(dbgDataB)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mA mirrors the zero-register instance, mB the plain one.
  logic [31:0] mA [32];
  logic [31:0] mB [32];
  bit          clearing = 1'b0;
  int          clrIdx = 0;
  bit          doneNow = 1'b0;
  logic        lastBusy, lastDone;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expA(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && we && !clearing && a == wrAddr) return wrData;
    return mA[a];
  endfunction

  function automatic logic [31:0] expB(input logic [4:0] a);
    if (BYP && we && !clearing && a == wrAddr) return wrData;
    return mB[a];
  endfunction

  task automatic modelUpdate();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mA[i] = '0;
        mB[i] = '0;
      end
      clearing = 1'b0;
      doneNow  = 1'b0;
      clrIdx   = 0;
    end else begin
      doneNow = 1'b0;
      if (clearing) begin
        mA[clrIdx] = '0;
        mB[clrIdx] = '0;
        if (clrIdx == 31) begin
          clearing = 1'b0;
          doneNow  = 1'b1;
        end else begin
          clrIdx++;
        end
      end else begin
        if (we) begin
          if (wrAddr != 5'd0) mA[wrAddr] = wrData;
          mB[wrAddr] = wrData;
        end
        if (clrReq) begin
          clearing = 1'b1;
          clrIdx   = 0;
        end
      end
    end
  endtask

  task automatic cycle(input bit doChk);
    @(negedge clk);
    lastBusy = busy;
    lastDone = clrDone;
    if (doChk) begin
      chk("busy", {31'b0, busy}, {31'b0, clearing});
      chk("clr_done", {31'b0, clrDone}, {31'b0, doneNow});
      chk("busyB", {31'b0, busyB}, {31'b0, clearing});
      chk("clr_doneB", {31'b0, clrDoneB}, {31'b0, doneNow});
      chk("rd0", rdData[31:0], expA(rdAddr[4:0]));
      chk("rd1", rdData[63:32], expA(rdAddr[9:5]));
      chk("dbg", dbgData, mA[dbgAddr]);
      chk("rdB", rdDataB, expB(rdAddr[4:0]));
      chk("dbgB", dbgDataB, mB[dbgAddr]);
    end
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] eB;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int busyCnt, doneCnt, cnt;

    tbl[0] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0,
               BYP ? 32'h12345678 : 32'h0, 32'h0, BYP ? 32'h12345678 : 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 32'h12345678, 32'h0, 32'h12345678};
    tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7,
               32'h0, 32'h12345678, BYP ? 32'hFFFFFFFF : 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF};
    tbl[4] = '{1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd7,
               BYP ? 32'hA5A5A5A5 : 32'h0, 32'h12345678, BYP ? 32'hA5A5A5A5 : 32'h0};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};

    rst = 1'b1; we = 1'b0; wrAddr = '0; wrData = '0; clrReq = 1'b0;
    rdAddr = '0; dbgAddr = '0;
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b0;

    // Reset wipes a freshly written register.
    we = 1'b1; wrAddr = 5'd5; wrData = 32'hDEADBEEF;
    cycle(1'b1);
    we = 1'b0; rdAddr = {5'd5, 5'd5}; dbgAddr = 5'd5;
    #1;
    chk("t1_prewrite", dbgData, 32'hDEADBEEF);
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    #1;
    chk("t1_rd0", rdData[31:0], 32'h0);
    chk("t1_rd1", rdData[63:32], 32'h0);
    chk("t1_dbg", dbgData, 32'h0);
    chk("t1_busy", {31'b0, busy}, 32'h0);

    // Directed write/read table, including zero register and same-cycle read.
    for (int i = 0; i < 6; i++) begin
      we = tbl[i].we; wrAddr = tbl[i].wa; wrData = tbl[i].wd;
      rdAddr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("tbl%0d_p0", i), rdData[31:0], tbl[i].e0);
      chk($sformatf("tbl%0d_p1", i), rdData[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_B", i), rdDataB, tbl[i].eB);
      cycle(1'b1);
    end
    we = 1'b0;

    // Full bulk clear with a dropped write during busy.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wrAddr = 5'(i); wrData = 32'(i);
      cycle(1'b1);
    end
    we = 1'b0;
    clrReq = 1'b1;
    cycle(1'b1);
    clrReq = 1'b0;
    busyCnt = 0; doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      we = (c == 20); wrAddr = 5'd9; wrData = 32'h99;
      clrReq = (c == 12);
      cycle(1'b1);
      busyCnt += int'(lastBusy);
      doneCnt += int'(lastDone);
    end
    we = 1'b0; clrReq = 1'b0;
    chk("t5_busy_cycles", 32'(busyCnt), 32'd32);
    chk("t5_done_pulses", 32'(doneCnt), 32'd1);
    for (int i = 0; i < 32; i++) begin
      dbgAddr = 5'(i); rdAddr = {5'(i), 5'(i)};
      #1;
      chk("t5_cleared", dbgData, 32'h0);
      cycle(1'b1);
    end

    // Reset during clear aborts the engine without a done pulse.
    for (int i = 20; i < 32; i++) begin
      we = 1'b1; wrAddr = 5'(i); wrData = 32'hF0 + 32'(i);
      cycle(1'b1);
    end
    we = 1'b0;
    clrReq = 1'b1;
    cycle(1'b1);
    clrReq = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 9; c++) begin
      cycle(1'b1);
      cnt += int'(lastBusy);
    end
    chk("t6_reach_busy9", 32'(cnt), 32'd9);
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    cycle(1'b1);
    chk("t6_busy_after_rst", {31'b0, lastBusy}, 32'h0);
    chk("t6_done_after_rst", {31'b0, lastDone}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbgAddr = 5'(i);
      #1;
      chk("t6_cleared", dbgData, 32'h0);
      cycle(1'b1);
    end
    clrReq = 1'b1;
    cycle(1'b1);
    clrReq = 1'b0;
    cycle(1'b1);
    chk("t6_restart", {31'b0, lastBusy}, 32'h1);
    for (int c = 0; c < 36; c++) cycle(1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 149) == 0);
      we     = 1'($urandom);
      wrAddr = 5'($urandom);
      wrData = $urandom;
      rdAddr[4:0] = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom);
      rdAddr[9:5] = ($urandom_range(0, 3) == 0) ? rdAddr[4:0] : 5'($urandom);
      dbgAddr = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom);
      clrReq = ($urandom_range(0, 59) == 0);
      cycle(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
